// File: rtl/square_seq.sv
// Sequencer that latches host-programmed settings for the square-wave generator
// and runs a counted series of bursts, each followed by a run-low gap.
module square_seq #(
    parameter int GAP_W    = 32,
    parameter int DUTY_MAX = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        ofs_kill,
    output logic [31:0] freq,
    output logic [15:0] duty,
    output logic [15:0] cycles,
    output logic        run,
    output logic        busy,
    output logic        done,
    output logic [15:0] burst_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [2:0] A_FREQ   = 3'd0;
    localparam logic [2:0] A_DUTY   = 3'd1;
    localparam logic [2:0] A_CYCLES = 3'd2;
    localparam logic [2:0] A_CTRL   = 3'd3;
    localparam logic [2:0] A_BURSTS = 3'd4;
    localparam logic [2:0] A_GAP    = 3'd5;

    localparam logic [15:0]      DUTY_MAX_C = 16'(DUTY_MAX);
    localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

    logic [2:0]       state_q, state_d;
    logic [31:0]      freq_sh_q, freq_sh_d;
    logic [15:0]      duty_sh_q, duty_sh_d;
    logic [15:0]      cycles_sh_q, cycles_sh_d;
    logic [15:0]      bursts_sh_q, bursts_sh_d;
    logic [GAP_W-1:0] gap_sh_q, gap_sh_d;
    logic [31:0]      freq_q, freq_d;
    logic [15:0]      duty_q, duty_d;
    logic [15:0]      cycles_q, cycles_d;
    logic [15:0]      burst_cnt_q, burst_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             seen_q, seen_d;
    logic             run_q, run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_cmd;
    logic             stop_cmd;
    logic [15:0]      cnt_inc;

    always_comb begin
        freq_sh_d   = freq_sh_q;
        duty_sh_d   = duty_sh_q;
        cycles_sh_d = cycles_sh_q;
        bursts_sh_d = bursts_sh_q;
        gap_sh_d    = gap_sh_q;
        start_cmd   = 1'b0;
        stop_cmd    = 1'b0;
        if (wr_en) begin
            case (wr_addr)
                A_FREQ:   freq_sh_d   = wr_data;
                A_DUTY:   duty_sh_d   = (wr_data[15:0] > DUTY_MAX_C) ? DUTY_MAX_C : wr_data[15:0];
                A_CYCLES: cycles_sh_d = wr_data[15:0];
                A_BURSTS: bursts_sh_d = wr_data[15:0];
                A_GAP:    gap_sh_d    = wr_data[GAP_W-1:0];
                A_CTRL: begin
                    stop_cmd  = wr_data[1];
                    start_cmd = wr_data[0] & ~wr_data[1];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        freq_d      = freq_q;
        duty_d      = duty_q;
        cycles_d    = cycles_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        seen_d      = seen_q;
        cnt_inc     = burst_cnt_q + 16'd1;

        if (stop_cmd) begin
            state_d = S_IDLE;
        end else if (start_cmd) begin
            freq_d      = freq_sh_q;
            duty_d      = duty_sh_q;
            cycles_d    = cycles_sh_q;
            burst_cnt_d = 16'd0;
            state_d     = S_ARM;
        end else begin
            case (state_q)
                S_ARM: begin
                    seen_d  = 1'b0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    if (ofs_kill) begin
                        seen_d = 1'b1;
                    end else if (seen_q) begin
                        // A low ofs_kill only ends a burst after it was seen high in this window.
                        burst_cnt_d = cnt_inc;
                        seen_d      = 1'b0;
                        if (bursts_sh_q != 16'd0 && cnt_inc == bursts_sh_q) begin
                            state_d = S_DONE;
                        end else begin
                            gap_cnt_d = (gap_sh_q == '0) ? GAP_ONE : gap_sh_q;
                            state_d   = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q <= GAP_ONE) begin
                        seen_d  = 1'b0;
                        state_d = S_RUN;
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_ONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        run_d  = (state_d == S_RUN);
        busy_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            freq_sh_q   <= '0;
            duty_sh_q   <= '0;
            cycles_sh_q <= '0;
            bursts_sh_q <= '0;
            gap_sh_q    <= '0;
            freq_q      <= '0;
            duty_q      <= '0;
            cycles_q    <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            seen_q      <= 1'b0;
            run_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_sh_q   <= freq_sh_d;
            duty_sh_q   <= duty_sh_d;
            cycles_sh_q <= cycles_sh_d;
            bursts_sh_q <= bursts_sh_d;
            gap_sh_q    <= gap_sh_d;
            freq_q      <= freq_d;
            duty_q      <= duty_d;
            cycles_q    <= cycles_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            seen_q      <= seen_d;
            run_q       <= run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign freq      = freq_q;
    assign duty      = duty_q;
    assign cycles    = cycles_q;
    assign run       = run_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_square_seq.sv
// Directed bench for square_seq: a vector table for register/start behaviour plus
// hand-written burst, gap, stop, restart and mid-run reset sequences.
module tb_square_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = 3'd0;
    logic [31:0] wr_data = 32'd0;
    logic        ofs_kill = 1'b0;
    logic [31:0] freq;
    logic [15:0] duty;
    logic [15:0] cycles;
    logic        run;
    logic        busy;
    logic        done;
    logic [15:0] burst_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int run_rises = 0;
    logic run_prev = 1'b0;

    square_seq #(.GAP_W(32), .DUTY_MAX(10000)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ofs_kill(ofs_kill), .freq(freq), .duty(duty), .cycles(cycles), .run(run),
        .busy(busy), .done(done), .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] freq_wr;
        logic [31:0] duty_wr;
        logic [31:0] cyc_wr;
        logic [15:0] exp_duty;
        logic [15:0] exp_cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are observed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (done === 1'b1) done_seen++;
        if (run === 1'b1 && run_prev === 1'b0) run_rises++;
        run_prev = run;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0; wr_data = 32'd0;
    endtask

    // Generator model for one burst: ofs_kill high one clock, then low.
    task automatic burst();
        ofs_kill = 1'b1;
        tick();
        ofs_kill = 1'b0;
        tick();
    endtask

    task automatic count_gap(output int low);
        low = 0;
        while (run !== 1'b1 && low < 50) begin
            low++;
            tick();
        end
    endtask

    initial begin
        int low;
        int d0;
        int bad;

        vecs[0] = '{32'd1000,       32'd5000,       32'd3,        16'd5000,  16'd3};
        vecs[1] = '{32'hFFFF_FFFF,  32'd12000,      32'd0,        16'd10000, 16'd0};
        vecs[2] = '{32'd7,          32'd10000,      32'd65535,    16'd10000, 16'd65535};
        vecs[3] = '{32'd0,          32'd10001,      32'd1,        16'd10000, 16'd1};
        vecs[4] = '{32'd5,          32'h0001_0005,  32'h0003_0002, 16'd5,    16'd2};
        vecs[5] = '{32'd123456,     32'h0000_FFFF,  32'd9,        16'd10000, 16'd9};

        // Reset state
        tick(); tick();
        chk("rst_freq", 64'(freq), 64'd0);
        chk("rst_duty", 64'(duty), 64'd0);
        chk("rst_cycles", 64'(cycles), 64'd0);
        chk("rst_flags", 64'({run, busy, done}), 64'd0);
        chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        rst_n = 1'b1;
        tick();

        // Vector table: program, start, check ARM-cycle outputs, stop
        for (int i = 0; i < 6; i++) begin
            wr(3'd0, vecs[i].freq_wr);
            wr(3'd1, vecs[i].duty_wr);
            wr(3'd2, vecs[i].cyc_wr);
            chk("shadow_no_live", 64'(freq), (i == 0) ? 64'd0 : 64'(vecs[i-1].freq_wr));
            wr(3'd3, 32'd1);
            chk("vec_freq", 64'(freq), 64'(vecs[i].freq_wr));
            chk("vec_duty", 64'(duty), 64'(vecs[i].exp_duty));
            chk("vec_cycles", 64'(cycles), 64'(vecs[i].exp_cyc));
            chk("vec_arm_run_busy", 64'({run, busy}), 64'b01);
            tick();
            chk("vec_run", 64'({run, busy}), 64'b11);
            wr(3'd3, 32'd2);
            chk("vec_stop", 64'({run, busy, done}), 64'd0);
            $display("vector %0d: freq=%0d duty=%0d cycles=%0d", i, freq, duty, cycles);
        end

        // Single burst with done
        wr(3'd0, 32'd1000); wr(3'd1, 32'd5000); wr(3'd2, 32'd3); wr(3'd4, 32'd1);
        d0 = done_seen;
        wr(3'd3, 32'd1);
        chk("t1_arm", 64'({run, busy, freq, duty, cycles}), {2'b01, 32'd1000, 16'd5000, 16'd3});
        tick();
        chk("t1_run", 64'(run), 64'd1);
        burst();
        chk("t1_done", 64'({done, run, busy, burst_cnt}), {3'b100, 16'd1});
        tick();
        chk("t1_after", 64'({done, busy}), 64'd0);
        chk("t1_done_count", 64'(done_seen - d0), 64'd1);
        $display("single burst: burst_cnt=%0d", burst_cnt);

        // Three bursts with GAP=5
        wr(3'd4, 32'd3); wr(3'd5, 32'd5);
        d0 = done_seen; run_rises = 0;
        wr(3'd3, 32'd1);
        tick();
        for (int b = 0; b < 3; b++) begin
            burst();
            if (b < 2) begin
                chk("t2_gap_state", 64'({run, busy, burst_cnt}), {2'b01, 16'(b + 1)});
                count_gap(low);
                chk("t2_gap_len", 64'(low), 64'd5);
            end
        end
        chk("t2_done", 64'({done, burst_cnt}), {1'b1, 16'd3});
        tick();
        chk("t2_run_windows", 64'(run_rises), 64'd3);
        chk("t2_done_count", 64'(done_seen - d0), 64'd1);
        $display("three bursts: burst_cnt=%0d windows=%0d", burst_cnt, run_rises);

        // GAP=0 gives a one-clock gap; stale low ofs_kill is not a burst end
        wr(3'd4, 32'd2); wr(3'd5, 32'd0);
        wr(3'd3, 32'd1);
        tick();
        burst();
        count_gap(low);
        chk("t3_gap_len", 64'(low), 64'd1);
        tick(); tick(); tick();
        chk("t3_stale", 64'({run, burst_cnt}), {1'b1, 16'd1});
        burst();
        chk("t3_done", 64'({done, burst_cnt}), {1'b1, 16'd2});
        tick();
        $display("gap zero: burst_cnt=%0d", burst_cnt);

        // Continuous mode, then stop+start together
        wr(3'd2, 32'd0);
        d0 = done_seen;
        wr(3'd3, 32'd1);
        tick();
        ofs_kill = 1'b1;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            tick();
            if (run !== 1'b1) bad++;
        end
        chk("t4_run_held", 64'(bad), 64'd0);
        wr(3'd3, 32'd3);
        chk("t4_stop_wins", 64'({run, busy, done, burst_cnt}), 64'd0);
        tick();
        chk("t4_no_done", 64'(done_seen - d0), 64'd0);
        ofs_kill = 1'b0;
        $display("continuous: stopped, burst_cnt=%0d", burst_cnt);

        // FREQ write during RUN, then restart
        wr(3'd0, 32'd1000); wr(3'd2, 32'd4);
        wr(3'd3, 32'd1);
        tick();
        wr(3'd0, 32'd2222);
        chk("t5_freq_hold", 64'({run, freq}), {1'b1, 32'd1000});
        d0 = done_seen;
        wr(3'd3, 32'd1);
        chk("t5_restart_arm", 64'({run, busy, freq}), {2'b01, 32'd2222});
        tick();
        chk("t5_restart_run", 64'(run), 64'd1);
        chk("t5_no_done", 64'(done_seen - d0), 64'd0);
        $display("restart: freq=%0d", freq);

        // Reset in the middle of a gap
        wr(3'd4, 32'd2); wr(3'd5, 32'd10);
        wr(3'd3, 32'd1);
        tick();
        burst();
        tick(); tick();
        chk("t6_in_gap", 64'({run, busy}), 64'b01);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outputs", 64'({run, busy, done, burst_cnt}), 64'd0);
        chk("t6_rst_live", 64'({freq, duty, cycles}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        wr(3'd3, 32'd1);
        chk("t6_start_zero", 64'({run, busy, freq, duty, cycles}), {2'b01, 64'd0});
        tick();
        chk("t6_run", 64'(run), 64'd1);
        wr(3'd3, 32'd2);
        $display("reset mid-gap: restarted with zero shadows");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
